instr_fetch: RTL

//  IF stage of the ARM32 pipeline. Owns the PC, drives the word address of intru_mem and

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/fetch_skid.sv | 44 ++++
 rtl/instr_fetch.sv | 116 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, reset/NOP constants and the IF/ID pipeline record.
package cpu_pkg;

   localparam int unsigned WORD_W      = 32;
   localparam int unsigned IMEM_ADDR_W = 11;
   localparam logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000;
   localparam logic [WORD_W-1:0] NOP_INSTR = 32'hE1A0_0000;

   typedef struct packed {
      logic [WORD_W-1:0] instr;
      logic [WORD_W-1:0] pc;
      logic              valid;
   } if_id_t;

   // Per-edge fetch action, already resolved for redirect-over-stall priority.
   typedef enum logic [1:0] {
      FA_RUN      = 2'd0,
      FA_STALL    = 2'd1,
      FA_REDIRECT = 2'd2
   } fetch_act_e;

   function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register for an instruction that returns while decode is stalled.
module fetch_skid
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic              unload,
   input  logic [WORD_W-1:0] in_instr,
   input  logic [WORD_W-1:0] in_pc,
   output logic [WORD_W-1:0] instr,
   output logic [WORD_W-1:0] pc,
   output logic              vld
);

   if_id_t ent_q;
   if_id_t ent_d;

   // A full entry is never overwritten; it drains only via unload or clear.
   always_comb begin
      ent_d = ent_q;
      if (clear || unload) begin
         ent_d.valid = 1'b0;
      end else if (load && !ent_q.valid) begin
         ent_d.instr = in_instr;
         ent_d.pc    = in_pc;
         ent_d.valid = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ent_q <= '0;
      end else begin
         ent_q <= ent_d;
      end
   end

   assign instr = ent_q.instr;
   assign pc    = ent_q.pc;
   assign vld   = ent_q.valid;

endmodule

// File: rtl/instr_fetch.sv
// IF stage: owns the PC, issues word addresses to intru_mem and registers returned data into IF/ID.
module instr_fetch #(
   parameter int unsigned ADDR_W   = cpu_pkg::IMEM_ADDR_W,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [31:0]       branch_target,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   output logic [31:0]       if_instr,
   output logic [31:0]       if_pc,
   output logic              if_valid
);

   import cpu_pkg::*;

   logic [WORD_W-1:0] pc_q, pc_d;
   logic [WORD_W-1:0] req_pc_q, req_pc_d;
   logic              req_vld_q, req_vld_d;
   if_id_t            if_q, if_d;

   fetch_act_e        act;
   logic              skid_load, skid_clear, skid_unload;
   logic [WORD_W-1:0] skid_instr, skid_pc;
   logic              skid_vld;

   fetch_skid u_skid (
      .clk      (clk),
      .rst      (rst),
      .load     (skid_load),
      .clear    (skid_clear),
      .unload   (skid_unload),
      .in_instr (imem_rdata),
      .in_pc    (req_pc_q),
      .instr    (skid_instr),
      .pc       (skid_pc),
      .vld      (skid_vld)
   );

   always_comb begin
      if (branch_taken) begin
         act = FA_REDIRECT;
      end else if (stall) begin
         act = FA_STALL;
      end else begin
         act = FA_RUN;
      end
   end

   always_comb begin
      pc_d        = pc_q;
      req_pc_d    = req_pc_q;
      req_vld_d   = req_vld_q;
      if_d        = if_q;
      skid_load   = 1'b0;
      skid_clear  = 1'b0;
      skid_unload = 1'b0;
      unique case (act)
         FA_REDIRECT: begin
            // Squash the in-flight read and any buffered instruction; IF/ID data holds but is invalid.
            pc_d        = word_align(branch_target);
            req_vld_d   = 1'b0;
            skid_clear  = 1'b1;
            if_d.valid  = 1'b0;
         end
         FA_STALL: begin
            // The PC does not advance, so the read returning this edge must be caught now or lost.
            req_vld_d = 1'b0;
            skid_load = req_vld_q && !skid_vld;
         end
         FA_RUN: begin
            if (skid_vld) begin
               if_d.instr  = skid_instr;
               if_d.pc     = skid_pc;
               if_d.valid  = 1'b1;
               skid_unload = 1'b1;
            end else if (req_vld_q) begin
               if_d.instr = imem_rdata;
               if_d.pc    = req_pc_q;
               if_d.valid = 1'b1;
            end else begin
               if_d.valid = 1'b0;
            end
            req_pc_d  = pc_q;
            req_vld_d = 1'b1;
            pc_d      = pc_q + 32'd4;
         end
         default: begin
            pc_d = pc_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= RESET_PC;
         req_pc_q  <= '0;
         req_vld_q <= 1'b0;
         if_q      <= '0;
      end else begin
         pc_q      <= pc_d;
         req_pc_q  <= req_pc_d;
         req_vld_q <= req_vld_d;
         if_q      <= if_d;
      end
   end

   assign imem_addr = pc_q[ADDR_W+1:2];
   assign if_instr  = if_q.instr;
   assign if_pc     = if_q.pc;
   assign if_valid  = if_q.valid;

endmodule
